// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity encodings, receiver
// FSM states and the baud divider rounding helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, phase held at zero while clr.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 2-of-3 majority bit detection, optional parity,
// 1-2 stop bits, per-word error flags and a valid/ready output with overrun reporting.
module uart_rx_param import uart_pkg::*; #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SMP_A   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_B   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_C   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP_END = SW'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_par_check
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic                 sync1_q, sync2_q, rx_prev_q, armed_q;
  uart_state_e          state_q;
  logic [SW-1:0]        cnt_q;
  logic [1:0]           smp_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q, ferr_q, zero_q;

  logic tick, clr, maj, mid_tick, end_tick, last_stop, done;
  logic frame_perr, frame_ferr, frame_brk;

  assign clr = (state_q == S_IDLE);

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Third sample is taken live so the majority is known on the tick of the last sample.
  assign maj       = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q) | (smp_q[0] & sync2_q);
  assign mid_tick  = tick && (cnt_q == SMP_C);
  assign end_tick  = tick && (cnt_q == SMP_END);
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  assign done      = (state_q == S_STOP) && mid_tick && last_stop;

  assign frame_ferr = ferr_q | ~maj;
  assign frame_brk  = zero_q & ~maj;

  always_comb begin
    frame_perr = 1'b0;
    if (PARITY == PAR_ODD) begin
      frame_perr = ~((^shreg_q) ^ par_q);
    end else if (PARITY == PAR_EVEN) begin
      frame_perr = (^shreg_q) ^ par_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      armed_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      smp_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      overrun   <= 1'b0;

      if (valid && ready) begin
        valid <= 1'b0;
      end

      if (tick) begin
        cnt_q <= (cnt_q == SMP_END) ? '0 : cnt_q + 1'b1;
        if (cnt_q == SMP_A || cnt_q == SMP_B) begin
          smp_q <= {smp_q[0], sync2_q};
        end
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // After a break the line must return high before a new start is accepted.
          if (sync2_q) begin
            armed_q <= 1'b1;
          end
          if (armed_q && rx_prev_q && !sync2_q) begin
            state_q    <= S_START;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b1;
          end
        end
        S_START: begin
          if (mid_tick && maj) begin
            state_q <= S_IDLE;
          end else if (end_tick) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (mid_tick) begin
            shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (maj) begin
              zero_q <= 1'b0;
            end
          end
          if (end_tick && bit_idx_q == BW'(DATA_BITS)) begin
            state_q <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid_tick) begin
            par_q <= maj;
            if (maj) begin
              zero_q <= 1'b0;
            end
          end
          if (end_tick) begin
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid_tick) begin
            if (!maj) begin
              ferr_q <= 1'b1;
            end else begin
              zero_q <= 1'b0;
            end
            if (last_stop) begin
              state_q <= S_IDLE;
              if (frame_brk) begin
                armed_q <= 1'b0;
              end
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (done) begin
        if (!valid || ready) begin
          data       <= shreg_q;
          parity_err <= frame_perr;
          frame_err  <= frame_ferr;
          break_det  <= frame_brk;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
